// File: rtl/pc_fetch_unit.sv
// Purpose: single-outstanding instruction fetch with a held decode slot, branch redirect and misalignment trap.
// Latency: instr_valid 1 cycle after imem_valid; next imem_req 1 cycle after the decode handshake.
// Backpressure: instr_ready=0 holds instr/instr_pc/instr_valid stable and suppresses new fetches.
//
// Ports:
//   clk, rst                - rising-edge clock, asynchronous active-high reset
//   imem_req, imem_addr     - fetch request and its address (the current PC)
//   imem_rdata, imem_valid  - fetch response, accepted only while fetching
//   instr, instr_pc         - held instruction word and its address
//   instr_valid/instr_ready - decode handshake
//   branch, EQ, ImmOp       - redirect controls, sampled only on the handshake
//   trap                    - sticky misaligned-target fault
//   retired                 - count of consumed instructions (wraps)
module pc_fetch_unit #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic [WIDTH-1:0] imem_rdata,
   input  logic             imem_valid,
   output logic [WIDTH-1:0] instr,
   output logic [WIDTH-1:0] instr_pc,
   output logic             instr_valid,
   input  logic             instr_ready,
   input  logic             branch,
   input  logic             EQ,
   input  logic [WIDTH-1:0] ImmOp,
   output logic             trap,
   output logic [WIDTH-1:0] retired
);

   localparam logic [WIDTH-1:0] INSTR_BYTES = WIDTH'(4);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      TRAP  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_nxt;
   logic [WIDTH-1:0] target;
   logic             misaligned;
   logic             capture;
   logic             fire;

   // Redirect target is formed from the held instruction's address; the sum
   // wraps naturally at WIDTH bits.
   assign target     = (branch && EQ) ? (instr_pc + ImmOp) : (instr_pc + INSTR_BYTES);
   assign misaligned = (target[1:0] != 2'b00);

   assign imem_addr  = pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      trap        = 1'b0;
      capture     = 1'b0;
      fire        = 1'b0;
      case (state)
         FETCH: begin
            // Reset parks the FSM in FETCH; the request stays low until
            // reset is released.
            imem_req = !rst;
            if (imem_valid) begin
               capture   = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            instr_valid = 1'b1;
            if (instr_ready) begin
               fire = 1'b1;
               if (misaligned) begin
                  // PC is left pointing at the faulting instruction.
                  state_nxt = TRAP;
               end else begin
                  pc_nxt    = target;
                  state_nxt = FETCH;
               end
            end
         end
         TRAP: begin
            trap = 1'b1;
         end
         default: begin
            state_nxt = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= RESET_PC;
         instr    <= '0;
         instr_pc <= '0;
         retired  <= '0;
      end else begin
         pc <= pc_nxt;
         if (capture) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
         end
         if (fire) begin
            retired <= retired + WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
   localparam int          W   = 32;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        imem_valid = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        branch = 1'b0;
   logic        EQ = 1'b0;
   logic [31:0] ImmOp = 32'h0;
   logic        trap;
   logic [31:0] retired;

   always #5 clk = ~clk;

   pc_fetch_unit #(.WIDTH(W), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .branch(branch), .EQ(EQ), .ImmOp(ImmOp),
      .trap(trap), .retired(retired)
   );

   // Reference model: what the fetch unit should look like after the next edge.
   typedef enum int {M_FETCH, M_HOLD, M_TRAP} mstate_t;
   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } ent_t;

   ent_t        exq[$];
   mstate_t     exp_state = M_FETCH;
   logic [31:0] exp_pc    = RPC;
   logic [31:0] exp_ret   = 32'h0;
   int          checks    = 0;
   int          failures  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // One cycle of stimulus; the model advances with exactly the rules the
   // fetch unit must follow for the coming clock edge.
   task automatic step(input bit imv, input logic [31:0] rd, input bit rdy,
                       input bit br, input bit eq, input logic [31:0] imm);
      logic [31:0] nxt;
      @(negedge clk); #1;
      imem_valid  = imv;
      imem_rdata  = rd;
      instr_ready = rdy;
      branch      = br;
      EQ          = eq;
      ImmOp       = imm;
      case (exp_state)
         M_FETCH: if (imv) begin
            exq.push_back('{word: rd, pc: exp_pc});
            exp_state = M_HOLD;
         end
         M_HOLD: if (rdy) begin
            nxt     = (br && eq) ? exp_pc + imm : exp_pc + 32'd4;
            exp_ret = exp_ret + 32'd1;
            if (nxt[1:0] != 2'b00) exp_state = M_TRAP;
            else begin
               exp_pc    = nxt;
               exp_state = M_FETCH;
            end
         end
         default: ;
      endcase
   endtask

   task automatic do_reset(input bit late_valid);
      @(negedge clk); #1;
      rst         = 1'b1;
      imem_valid  = late_valid;
      imem_rdata  = $urandom;
      instr_ready = 1'b1;
      exq.delete();
      exp_state = M_FETCH;
      exp_pc    = RPC;
      exp_ret   = 32'h0;
      #1;
      chk("async_instr_valid", 32'(instr_valid), 32'h0);
      chk("async_imem_req", 32'(imem_req), 32'h0);
      chk("async_retired", retired, 32'h0);
      @(negedge clk); #1;
      rst         = 1'b0;
      imem_valid  = 1'b0;
      instr_ready = 1'b0;
   endtask

   // Fetch one instruction after some idle cycles, hold it, then consume it.
   task automatic one(input int waits, input logic [31:0] word, input int holds,
                      input bit br, input bit eq, input logic [31:0] imm);
      for (int i = 0; i < waits; i++) step(1'b0, $urandom, 1'b1, 1'b1, 1'b1, 32'h2);
      step(1'b1, word, 1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < holds; i++) step(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b1, 1'b1, 32'h2);
      step(1'b0, 32'h0, 1'b1, br, eq, imm);
   endtask

   // Monitor: compares DUT outputs against the model every cycle and retires
   // scoreboard entries when a handshake is seen.
   logic prev_valid = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_imem_req", 32'(imem_req), 32'h0);
            chk("rst_instr_valid", 32'(instr_valid), 32'h0);
            chk("rst_trap", 32'(trap), 32'h0);
            chk("rst_retired", retired, 32'h0);
            chk("rst_instr", instr, 32'h0);
            chk("rst_instr_pc", instr_pc, 32'h0);
            chk("rst_imem_addr", imem_addr, RPC);
            prev_valid = 1'b0;
         end else begin
            if (prev_valid && instr_ready && exq.size() > 0) void'(exq.pop_front());
            chk("imem_req", 32'(imem_req), 32'(exp_state == M_FETCH));
            if (exp_state == M_FETCH) chk("imem_addr", imem_addr, exp_pc);
            chk("instr_valid", 32'(instr_valid), 32'(exp_state == M_HOLD));
            chk("trap", 32'(trap), 32'(exp_state == M_TRAP));
            chk("retired", retired, exp_ret);
            if (instr_valid) begin
               if (exq.size() > 0) begin
                  chk("instr", instr, exq[0].word);
                  chk("instr_pc", instr_pc, exq[0].pc);
               end else begin
                  chk("valid_without_fetch", 32'(instr_valid), 32'h0);
               end
            end
            prev_valid = instr_valid;
         end
      end
   end

   initial begin
      int          k;
      logic [31:0] imm;
      do_reset(1'b0);
      // First fetch after three idle cycles, then straight-line code.
      one(3, 32'h0050_0093, 0, 1'b0, 1'b0, 32'h0);
      one(0, 32'h0000_0013, 0, 1'b0, 1'b0, 32'h0);
      // Taken branch from 8 back to 0.
      one(0, 32'hFE00_0CE3, 0, 1'b1, 1'b1, 32'hFFFF_FFF8);
      one(1, 32'h0000_0113, 0, 1'b0, 1'b0, 32'h0);
      one(0, 32'h0000_0193, 0, 1'b0, 1'b0, 32'h0);
      // Not-taken branch at 8 falls through to 12.
      one(0, 32'hFE00_0CE3, 0, 1'b1, 1'b0, 32'hFFFF_FFF8);
      // Five cycles of backpressure at 12.
      one(2, 32'h0000_0213, 5, 1'b0, 1'b0, 32'h0);
      // Misaligned taken branch at 16 traps; trap must be absorbing.
      one(0, 32'h0000_0163, 0, 1'b1, 1'b1, 32'h2);
      for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 32'h0);
      do_reset(1'b1);
      // Reset while holding the instruction at 16.
      for (int i = 0; i < 4; i++) one(0, $urandom, 0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      do_reset(1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0 || (exp_state == M_TRAP && $urandom_range(0, 3) == 0)) begin
            do_reset(1'($urandom_range(0, 1)));
         end else begin
            k   = int'($urandom_range(0, 64)) - 32;
            imm = 32'(k * 4);
            if ($urandom_range(0, 15) == 0) imm = imm + 32'($urandom_range(1, 3));
            step(1'($urandom_range(0, 2) == 0), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), imm);
         end
      end
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
